// File: rtl/sine_seq_pkg.sv
// Shared types and phase arithmetic for the wave-table sequencer.
// Defaults describe the 30-entry, 5.8 fixed-point configuration.
package sine_seq_pkg;

  localparam int unsigned DEF_TABLE_LEN = 30;
  localparam int unsigned DEF_ADDR_W    = 5;
  localparam int unsigned DEF_FRAC_W    = 8;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_CNT_W     = 16;

  localparam int unsigned PHASE_W = DEF_ADDR_W + DEF_FRAC_W;
  localparam logic [31:0] WRAP_K  = 32'(DEF_TABLE_LEN) << DEF_FRAC_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPT,
    OUT
  } state_t;

  // One add and at most one subtract keeps the phase inside [0, wrap).
  // Valid because both acc and the integer part of step are below the table length.
  function automatic logic [31:0] phase_wrap(input logic [31:0] acc,
                                             input logic [31:0] step,
                                             input logic [31:0] wrap);
    logic [31:0] sum;
    sum = acc + step;
    if (sum >= wrap) sum = sum - wrap;
    return sum;
  endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// Fractional phase accumulator: loads an integer start index, advances by a
// fixed-point step and wraps exactly modulo TABLE_LEN.
module sine_phase_acc
  import sine_seq_pkg::*;
#(
  parameter int unsigned TABLE_LEN = DEF_TABLE_LEN,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned FRAC_W    = DEF_FRAC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [ADDR_W-1:0]          load_idx,
  input  logic                       advance,
  input  logic [ADDR_W+FRAC_W-1:0]   step,
  output logic [ADDR_W-1:0]          nxt_idx
);

  localparam int unsigned PW   = ADDR_W + FRAC_W;
  localparam logic [31:0] WRAP = 32'(TABLE_LEN) << FRAC_W;

  logic [PW-1:0] acc;
  logic [PW-1:0] acc_adv;
  logic [PW-1:0] acc_nxt;

  always_comb begin
    acc_adv = PW'(phase_wrap(32'(acc), 32'(step), WRAP));
    // NOTE: acc_nxt takes a default before the branches, so no latch is inferred.
    acc_nxt = acc;
    if (load) begin
      // Out-of-range start indices restart the table at entry 0.
      acc_nxt = (32'(load_idx) >= TABLE_LEN) ? '0 : {load_idx, FRAC_W'(0)};
    end else if (advance) begin
      acc_nxt = acc_adv;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc_nxt;
  end

  // The address register in the controller is loaded alongside acc, so it
  // takes the integer part of the value acc is about to become.
  assign nxt_idx = acc_nxt[PW-1:FRAC_W];

endmodule

// File: rtl/sine_seq_ctrl.sv
// Wave-table playback sequencer: READ/CAPT/OUT per sample against a 1-cycle
// synchronous ROM, valid/ready output stream, bursts, continuous play, clean stop.
module sine_seq_ctrl
  import sine_seq_pkg::*;
#(
  parameter int unsigned TABLE_LEN = DEF_TABLE_LEN,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned FRAC_W    = DEF_FRAC_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDR_W+FRAC_W-1:0] step,
  input  logic [ADDR_W-1:0]        start_idx,
  input  logic [CNT_W-1:0]         n_samples,
  output logic                     rom_rd,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [DATA_W-1:0]        sample_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned PW = ADDR_W + FRAC_W;

  state_t            state;
  logic [PW-1:0]     step_r;
  logic [CNT_W-1:0]  n_r;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              stop_pend;
  logic              load;
  logic              advance;
  logic              last;
  logic [ADDR_W-1:0] nxt_idx;

  // A stop arriving together with start keeps the block idle.
  assign load    = (state == IDLE) && start && !stop;
  assign advance = (state == OUT) && sample_ready;
  assign cnt_inc = cnt + CNT_W'(1);
  // n_r == 0 is continuous play: cnt is free-running and never ends the run.
  assign last    = stop_pend || stop || ((n_r != '0) && (cnt_inc == n_r));

  sine_phase_acc #(
    .TABLE_LEN (TABLE_LEN),
    .ADDR_W    (ADDR_W),
    .FRAC_W    (FRAC_W)
  ) u_phase_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_idx (start_idx),
    .advance  (advance),
    .step     (step_r),
    .nxt_idx  (nxt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      step_r       <= '0;
      n_r          <= '0;
      cnt          <= '0;
      stop_pend    <= 1'b0;
      rom_rd       <= 1'b0;
      rom_addr     <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all branches see pre-edge values.
      rom_rd <= 1'b0;
      done   <= 1'b0;
      if (stop && (state != IDLE)) stop_pend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (load) begin
            step_r   <= step;
            n_r      <= n_samples;
            cnt      <= '0;
            busy     <= 1'b1;
            rom_rd   <= 1'b1;
            rom_addr <= nxt_idx;
            state    <= READ;
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          sample_data  <= rom_data;
          sample_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (sample_ready) begin
            cnt          <= cnt_inc;
            sample_valid <= 1'b0;
            if (last) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else begin
              rom_rd   <= 1'b1;
              rom_addr <= nxt_idx;
              state    <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Scoreboard bench for sine_seq_ctrl: a table-level model queues expected ROM
// addresses and samples; a negedge monitor pops and compares DUT activity.
module tb_sine_seq_ctrl;

  localparam int TABLE_LEN = 30;
  localparam int ADDR_W    = 5;
  localparam int FRAC_W    = 8;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 16;
  localparam int PW        = ADDR_W + FRAC_W;
  localparam int ONE       = 1 << FRAC_W;

  // round(77 * sin(2*pi*i/30)) -- the wave table held in the external ROM
  localparam int SINE [TABLE_LEN] = '{
      0,  16,  31,  45,  57,  67,  73,  77,  77,  73,
     67,  57,  45,  31,  16,   0, -16, -31, -45, -57,
    -67, -73, -77, -77, -73, -67, -57, -45, -31, -16 };

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [PW-1:0]     step = '0;
  logic [ADDR_W-1:0] start_idx = '0;
  logic [CNT_W-1:0]  n_samples = '0;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              sample_valid;
  logic              sample_ready = 1'b0;
  logic [DATA_W-1:0] sample_data;
  logic              busy;
  logic              done;

  sine_seq_ctrl #(
    .TABLE_LEN (TABLE_LEN),
    .ADDR_W    (ADDR_W),
    .FRAC_W    (FRAC_W),
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .step         (step),
    .start_idx    (start_idx),
    .n_samples    (n_samples),
    .rom_rd       (rom_rd),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // External wave ROM: synchronous read, data valid the cycle after rom_rd.
  always @(posedge clk) if (rom_rd) rom_data <= DATA_W'(SINE[rom_addr]);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int                addr_q [$];
  logic [DATA_W-1:0] data_q [$];
  int                hs_cyc_q [$];
  int cyc = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;
  int ready_pct = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    sample_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Monitor: samples mid-cycle, pops expectations on every read and handshake.
  logic              prev_valid = 1'b0;
  logic              prev_ready = 1'b0;
  logic              prev_done  = 1'b0;
  logic              rst_d      = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_rd) begin
        rd_cnt++;
        if (addr_q.size() == 0) check("rom_rd_unexpected", 1, 0);
        else                    check("rom_addr", 32'(rom_addr), addr_q.pop_front());
        check("rd_while_valid", 32'(sample_valid), 0);
      end
      if (rst_d && prev_valid && !prev_ready) begin
        check("hold_valid", 32'(sample_valid), 1);
        check("hold_data", 32'(sample_data), 32'(prev_data));
      end
      if (sample_valid && sample_ready) begin
        hs_cnt++;
        hs_cyc_q.push_back(cyc);
        if (data_q.size() == 0) check("hs_unexpected", 1, 0);
        else                    check("sample_data", 32'(sample_data), 32'(data_q.pop_front()));
      end
      if (sample_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy_low", 32'(busy), 0);
        check("done_single", 32'(prev_done), 0);
      end
    end
    prev_valid = sample_valid;
    prev_ready = sample_ready;
    prev_data  = sample_data;
    prev_done  = done && rst_n;
    rst_d      = rst_n;
  end

  // Reference model: phase walks the table in fixed point, wrapping with modulo.
  task automatic push_expect(input int stp, input int idx, input int n);
    int phase;
    int a;
    phase = (idx >= TABLE_LEN) ? 0 : idx * ONE;
    for (int k = 0; k < n; k++) begin
      a = phase / ONE;
      addr_q.push_back(a);
      data_q.push_back(DATA_W'(SINE[a]));
      phase = (phase + stp) % (TABLE_LEN * ONE);
    end
  endtask

  task automatic issue_start(input int stp, input int idx, input int n, input bit with_stop);
    @(posedge clk); #1;
    start     = 1'b1;
    stop      = with_stop;
    step      = PW'(stp);
    start_idx = ADDR_W'(idx);
    n_samples = CNT_W'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    stop      = 1'b0;
    step      = PW'($urandom);
    start_idx = ADDR_W'($urandom);
    n_samples = CNT_W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int  base;
    bit  ok;
    base = done_cnt;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic flush_model();
    addr_q.delete();
    data_q.delete();
  endtask

  task automatic run_burst(input int stp, input int idx, input int n, input int pct,
                           input bit timing, input int restart_delay);
    int hs0, rd0, d0;
    hs0 = hs_cnt; rd0 = rd_cnt; d0 = done_cnt;
    ready_pct = pct;
    hs_cyc_q.delete();
    first_valid_cyc = -1;
    push_expect(stp, idx, n);
    issue_start(stp, idx, n, 1'b0);
    if (restart_delay >= 0) begin
      repeat (restart_delay) @(posedge clk);
      #1;
      check("busy_at_restart", 32'(busy), 1);
      start = 1'b1;
      step  = PW'(stp ^ 13'h0255);
      start_idx = ADDR_W'(idx + 9);
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(200 + n * 60);
    repeat (3) @(posedge clk);
    #1;
    check("burst_hs_count", hs_cnt - hs0, n);
    check("burst_rd_count", rd_cnt - rd0, n);
    check("burst_done_pulses", done_cnt - d0, 1);
    check("burst_addr_q_drained", addr_q.size(), 0);
    check("burst_busy_low", 32'(busy), 0);
    if (timing) begin
      check("first_valid_latency", first_valid_cyc - start_cyc, 3);
      for (int i = 1; i < hs_cyc_q.size(); i++)
        check("sample_period", hs_cyc_q[i] - hs_cyc_q[i-1], 3);
      if (hs_cyc_q.size() > 0) check("done_after_last_hs", done_cyc - hs_cyc_q[$], 1);
    end
    flush_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hs0, rd0, d0, stp, idx, n, pct;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",     32'(busy), 0);
    check("reset_valid",    32'(sample_valid), 0);
    check("reset_data",     32'(sample_data), 0);
    check("reset_rom_rd",   32'(rom_rd), 0);
    check("reset_rom_addr", 32'(rom_addr), 0);
    check("reset_done",     32'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full table walk at unit step with a 3-cycle sample period
    run_burst(16'h0100, 0, 30, 100, 1'b1, -1);
    // 1.5 step from 28: addresses 28, 29, 1, 2
    run_burst(16'h0180, 28, 4, 100, 1'b1, -1);
    // Largest legal step
    run_burst(TABLE_LEN * ONE - 1, 29, 5, 100, 1'b1, -1);
    // Start while busy with a different step is ignored
    run_burst(16'h0100, 3, 6, 70, 1'b0, 4);

    // Backpressure: ready held low for 5 cycles after the first valid
    hs0 = hs_cnt; rd0 = rd_cnt; d0 = done_cnt;
    ready_pct = 0;
    push_expect(16'h0100, 5, 2);
    issue_start(16'h0100, 5, 2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sample_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", 32'(seen), 1);
    repeat (5) @(posedge clk);
    ready_pct = 100;
    wait_done(200);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hs_count", hs_cnt - hs0, 2);
    check("bp_rd_count", rd_cnt - rd0, 2);
    check("bp_done_pulses", done_cnt - d0, 1);
    flush_model();

    // Continuous play, stop landing in a READ cycle
    hs0 = hs_cnt; rd0 = rd_cnt; d0 = done_cnt;
    ready_pct = 100;
    push_expect(16'h0080, 7, 64);
    issue_start(16'h0080, 7, 0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (hs_cnt - hs0 >= 5) break;
    end
    stop = 1'b1;
    @(negedge clk);
    check("stop_in_read", 32'(rom_rd), 1);
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(100);
    repeat (4) @(posedge clk);
    #1;
    check("stop_hs_count", hs_cnt - hs0, 6);
    check("stop_rd_count", rd_cnt - rd0, 6);
    check("stop_done_pulses", done_cnt - d0, 1);
    check("stop_busy_low", 32'(busy), 0);
    flush_model();

    // start and stop together in IDLE: nothing happens
    rd0 = rd_cnt; d0 = done_cnt;
    issue_start(16'h0100, 0, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("start_stop_busy", 32'(busy), 0);
      @(posedge clk); #1;
    end
    check("start_stop_no_rd", rd_cnt - rd0, 0);
    check("start_stop_no_done", done_cnt - d0, 0);

    // Randomized bursts, including out-of-range start indices
    for (int t = 0; t < 10; t++) begin
      stp = $urandom_range(0, TABLE_LEN * ONE - 1);
      idx = $urandom_range(0, 31);
      n   = $urandom_range(1, 10);
      pct = $urandom_range(30, 100);
      run_burst(stp, idx, n, pct, 1'b0, -1);
    end

    // Reset while holding a sample in OUT
    ready_pct = 0;
    push_expect(16'h0100, 7, 64);
    issue_start(16'h0100, 7, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sample_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_valid_seen", 32'(seen), 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_valid",    32'(sample_valid), 0);
    check("rst_mid_data",     32'(sample_data), 0);
    check("rst_mid_busy",     32'(busy), 0);
    check("rst_mid_rom_rd",   32'(rom_rd), 0);
    check("rst_mid_rom_addr", 32'(rom_addr), 0);
    check("rst_mid_done",     32'(done), 0);
    flush_model();
    rd0 = rd_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_rd", rd_cnt - rd0, 0);
    check("rst_stays_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
